// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec_pkg
// Brief    : Shared types and defaults for the vector operand fetch block.
// Revision : 1.0 - initial release
// ============================================================================
package vec_pkg;

  localparam int c_fifo_depth = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/vec_pair_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vec_pair_fifo
// Brief    : First-word-fall-through FIFO holding paired {A, B} elements.
// Revision : 1.0 - initial release
// ============================================================================
module vec_pair_fifo
  import vec_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = c_fifo_depth,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign empty    = (r_count == '0);
  assign full     = (r_count == (AW+1)'(DEPTH));
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/vec_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : vec_operand_fetch
// Brief    : Streams strided A/B operand vectors from SRAM as (A, B) beats.
//            Optional: VEC_FETCH_BCAST_EN enables a read-once broadcast B.
// Revision : 1.0 - initial release
// ============================================================================
module vec_operand_fetch
  import vec_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  parameter  int ADDR_WIDTH   = 16,
  parameter  int MAX_ELEMENTS = 4096,
  parameter  int FIFO_DEPTH   = c_fifo_depth,
  localparam int CW           = $clog2(MAX_ELEMENTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  binary,
  input  logic                  bcast_b,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [ADDR_WIDTH-1:0] stride_a,
  input  logic [ADDR_WIDTH-1:0] stride_b,
  input  logic [CW-1:0]         num_elements,
  output logic                  sram_rd_en,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic [DATA_WIDTH-1:0] a_data,
  output logic [DATA_WIDTH-1:0] b_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t          r_state, w_state_nxt;
  logic                  r_binary, r_bcast, r_b_fetched, r_zero_run, r_done;
  logic [ADDR_WIDTH-1:0] r_addr_a, r_addr_b, r_stride_a, r_stride_b;
  logic [CW-1:0]         r_issue_left, r_out_left;
  logic [FCW-1:0]        r_inflight;
  logic                  r_ret_valid, r_ret_b, r_ret_push;
  logic [DATA_WIDTH-1:0] r_a_hold, r_b_hold, w_b_lane;
  logic [FCW-1:0]        w_count;
  logic                  w_empty, w_unused_full, w_push, w_pop;
  logic                  w_accept, w_credit, w_issue_a, w_issue_b, w_needs_b, w_drain_exit, w_bcast_req;
  logic [2*DATA_WIDTH-1:0] w_push_data, w_head;

`ifdef VEC_FETCH_BCAST_EN
  assign w_bcast_req = binary && bcast_b;
`else
  logic w_unused_bcast;
  assign w_unused_bcast = bcast_b;
  assign w_bcast_req    = 1'b0;
`endif

  // Credit covers both buffered pairs and reads whose data has not yet landed.
  assign w_credit     = ({1'b0, w_count} + {1'b0, r_inflight}) < (FCW+1)'(FIFO_DEPTH);
  assign w_accept     = (r_state == IDLE) && start && !r_done;
  assign w_needs_b    = r_binary && !(r_bcast && r_b_fetched);
  assign w_issue_a    = (r_state == FETCH_A) && w_credit;
  assign w_issue_b    = (r_state == FETCH_B);
  assign w_pop        = out_ready && !w_empty;
  assign w_drain_exit = (r_out_left == '0) || ((r_out_left == CW'(1)) && w_pop);

  assign sram_rd_en = w_issue_a || w_issue_b;
  assign sram_addr  = w_issue_b ? r_addr_b : (w_issue_a ? r_addr_a : '0);

  assign w_push      = r_ret_valid && r_ret_push;
  assign w_b_lane    = r_binary ? r_b_hold : '0;
  assign w_push_data = r_ret_b ? {r_a_hold, sram_rdata} : {sram_rdata, w_b_lane};

  assign out_valid        = !w_empty;
  assign {a_data, b_data} = out_valid ? w_head : '0;
  assign busy             = (r_state != IDLE) || r_done;
  assign done             = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = (num_elements == '0) ? DONE : FETCH_A;
      FETCH_A: if (w_issue_a) begin
                 if (w_needs_b)                       w_state_nxt = FETCH_B;
                 else if (r_issue_left == CW'(1))     w_state_nxt = DRAIN;
               end
      FETCH_B: w_state_nxt = (r_issue_left == '0) ? DRAIN : FETCH_A;
      DRAIN:   if (w_drain_exit) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_binary     <= 1'b0;
      r_bcast      <= 1'b0;
      r_b_fetched  <= 1'b0;
      r_zero_run   <= 1'b0;
      r_done       <= 1'b0;
      r_addr_a     <= '0;
      r_addr_b     <= '0;
      r_stride_a   <= '0;
      r_stride_b   <= '0;
      r_issue_left <= '0;
      r_out_left   <= '0;
      r_inflight   <= '0;
      r_ret_valid  <= 1'b0;
      r_ret_b      <= 1'b0;
      r_ret_push   <= 1'b0;
      r_a_hold     <= '0;
      r_b_hold     <= '0;
    end else begin
      // A zero-length run reports done one cycle after passing through DONE.
      r_done      <= ((r_state == DRAIN) && w_drain_exit) || ((r_state == DONE) && r_zero_run);
      r_ret_valid <= sram_rd_en;
      r_ret_b     <= w_issue_b;
      r_ret_push  <= w_issue_b || (w_issue_a && !w_needs_b);
      if (w_accept) begin
        r_binary     <= binary;
        r_bcast      <= w_bcast_req;
        r_b_fetched  <= 1'b0;
        r_zero_run   <= (num_elements == '0);
        r_addr_a     <= base_a;
        r_addr_b     <= base_b;
        r_stride_a   <= stride_a;
        r_stride_b   <= stride_b;
        r_issue_left <= num_elements;
        r_out_left   <= num_elements;
      end else begin
        if (w_issue_a) begin
          r_addr_a     <= r_addr_a + r_stride_a;
          r_issue_left <= r_issue_left - 1'b1;
        end
        if (w_issue_b) begin
          r_addr_b    <= r_addr_b + r_stride_b;
          r_b_fetched <= 1'b1;
        end
        if (w_pop) r_out_left <= r_out_left - 1'b1;
      end
      case ({w_issue_a, w_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
      if (r_ret_valid && !r_ret_b) r_a_hold <= sram_rdata;
      if (r_ret_valid &&  r_ret_b) r_b_hold <= sram_rdata;
    end
  end

  vec_pair_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .count     (w_count),
    .empty     (w_empty),
    .full      (w_unused_full)
  );

endmodule
`default_nettype wire

// File: tb/tb_vec_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_operand_fetch
// Brief    : Table-driven scoreboard bench for vec_operand_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_operand_fetch;

  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int MAXE = 4096;
  localparam int CW   = $clog2(MAXE);
  localparam int FD   = 4;
`ifdef VEC_FETCH_BCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start, busy, done, binary, bcast_b;
  logic [AW-1:0] base_a, base_b, stride_a, stride_b, sram_addr;
  logic [CW-1:0] num_elements;
  logic          sram_rd_en, out_valid, out_ready;
  logic [DW-1:0] sram_rdata, a_data, b_data;

  always #5 clk = ~clk;

  vec_operand_fetch #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_ELEMENTS(MAXE), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .binary(binary), .bcast_b(bcast_b), .base_a(base_a), .base_b(base_b),
    .stride_a(stride_a), .stride_b(stride_b), .num_elements(num_elements),
    .sram_rd_en(sram_rd_en), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .a_data(a_data), .b_data(b_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic          binary;
    logic          bcast;
    logic [AW-1:0] base_a, base_b, stride_a, stride_b;
    int            n;
    int            exp_first;
    int            exp_done;
  } vec_t;

  logic [DW-1:0]   mem [65536];
  logic [AW-1:0]   exp_addr_q [$];
  logic [2*DW-1:0] exp_pair_q [$];
  int  n_vec = 0, n_err = 0;
  int  edge_cnt = 0, start_edge = 0, mon_cyc = 0;
  int  rd_cnt = 0, exp_rd = 0, first_valid = -1, done_cyc = -1, done_cnt = 0;
  bit  mon_en = 1'b0;
  vec_t vecs [7];
  vec_t bp, rv;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  always @(posedge clk) if (sram_rd_en) sram_rdata <= mem[sram_addr];

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard of read addresses and output pairs, plus cycle stamps.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_cyc = edge_cnt - start_edge;
      if (sram_rd_en) begin
        rd_cnt++;
        check("rd_queue_nonempty", exp_addr_q.size() > 0, 1);
        if (exp_addr_q.size() > 0) check("rd_addr", sram_addr, exp_addr_q.pop_front());
      end
      if (out_valid && first_valid < 0) first_valid = mon_cyc;
      if (out_valid) begin
        check("pair_queue_nonempty", exp_pair_q.size() > 0, 1);
        if (exp_pair_q.size() > 0) begin
          if (out_ready) check("pair_pop", {a_data, b_data}, exp_pair_q.pop_front());
          else           check("pair_hold", {a_data, b_data}, exp_pair_q[0]);
        end
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = mon_cyc;
      end
    end
  end

  task automatic load_model(input vec_t v);
    logic [AW-1:0] aa, ab;
    logic [DW-1:0] bval;
    exp_addr_q.delete();
    exp_pair_q.delete();
    aa = v.base_a;
    ab = v.base_b;
    bval = '0;
    for (int i = 0; i < v.n; i++) begin
      exp_addr_q.push_back(aa);
      if (v.binary && !(BCAST && v.bcast && i > 0)) begin
        exp_addr_q.push_back(ab);
        bval = mem[ab];
        ab = ab + v.stride_b;
      end
      exp_pair_q.push_back({mem[aa], v.binary ? bval : 8'h00});
      aa = aa + v.stride_a;
    end
    exp_rd = exp_addr_q.size();
  endtask

  task automatic start_run(input vec_t v);
    @(negedge clk);
    binary = v.binary; bcast_b = v.bcast;
    base_a = v.base_a; base_b = v.base_b;
    stride_a = v.stride_a; stride_b = v.stride_b;
    num_elements = CW'(v.n);
    start = 1'b1;
    load_model(v);
    rd_cnt = 0; first_valid = -1; done_cyc = -1; done_cnt = 0;
    start_edge = edge_cnt;
    @(posedge clk);
    mon_en = 1'b1;
    #1;
    start = 1'b0;
    // Configuration must have been latched; scramble it for the rest of the run.
    binary = ~v.binary; bcast_b = ~v.bcast;
    base_a = AW'($urandom); base_b = AW'($urandom);
    stride_a = AW'($urandom); stride_b = AW'($urandom);
    num_elements = CW'($urandom_range(1, 50));
    @(negedge clk);
    #1 check("busy_cycle1", busy, 1);
  endtask

  task automatic finish_run(input vec_t v, input bit timing);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt > 0) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    @(negedge clk);
    #1;
    check("busy_after_done", busy, 0);
    check("done_pulse_count", done_cnt, 1);
    check("rd_count", rd_cnt, exp_rd);
    check("pairs_left", exp_pair_q.size(), 0);
    if (timing) begin
      check("first_valid_cycle", first_valid, v.exp_first);
      check("done_cycle", done_cyc, v.exp_done);
    end
    mon_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = DW'(i) ^ DW'(i >> 8) ^ 8'h5A;
    for (int i = 0; i < 4; i++) mem[16'h0100 + i] = DW'(i + 1);
    start = 1'b0; binary = 1'b0; bcast_b = 1'b0; out_ready = 1'b1;
    base_a = '0; base_b = '0; stride_a = '0; stride_b = '0; num_elements = '0;

    repeat (3) @(negedge clk);
    #1 check("reset_outputs", {busy, done, sram_rd_en, out_valid, sram_addr, a_data, b_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    //            bin   bc    base_a    base_b    str_a     str_b     n  first done
    vecs[0] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0001, 16'h0000, 4, 3, 7};
    vecs[1] = '{1'b1, 1'b0, 16'h0010, 16'h0020, 16'h0002, 16'h0002, 3, 4, 9};
    vecs[2] = '{1'b1, 1'b0, 16'h0300, 16'h0400, 16'h0001, 16'h0001, 0, -1, 2};
    vecs[3] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h0001, 16'h0000, 4, 3, 7};
`ifdef VEC_FETCH_BCAST_EN
    vecs[4] = '{1'b1, 1'b1, 16'h0200, 16'h0300, 16'h0001, 16'h0001, 4, 4, 8};
`else
    vecs[4] = '{1'b1, 1'b1, 16'h0200, 16'h0300, 16'h0001, 16'h0001, 4, 4, 11};
`endif
    vecs[5] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0003, 16'h0000, 5, 3, 8};
    vecs[6] = '{1'b1, 1'b0, 16'h0080, 16'h9000, 16'hFFFF, 16'h0100, 2, 4, 7};

    for (int i = 0; i < 7; i++) begin
      start_run(vecs[i]);
      finish_run(vecs[i], 1'b1);
    end

    // Backpressure: credit limits reads to the FIFO depth, head holds steady.
    bp = '{1'b0, 1'b0, 16'h0500, 16'h0000, 16'h0001, 16'h0000, 8, 3, -1};
    out_ready = 1'b0;
    start_run(bp);
    repeat (19) @(negedge clk);
    #1;
    check("bp_reads", rd_cnt, FD);
    check("bp_rd_idle", sram_rd_en, 0);
    check("bp_head", {a_data, b_data}, {mem[16'h0500], 8'h00});
    @(negedge clk);
    start = 1'b1; base_a = 16'h0700; num_elements = CW'(3);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    finish_run(bp, 1'b0);

    // Reset in cycle 5 of a binary run, then a fresh run.
    rv = vecs[1];
    rv.n = 8;
    start_run(rv);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1 check("midrun_reset_outputs", {busy, done, sram_rd_en, out_valid, sram_addr, a_data, b_data}, 0);
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_run(vecs[1]);
    finish_run(vecs[1], 1'b1);
    start_run(vecs[4]);
    finish_run(vecs[4], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vec_operand_fetch.md
# vec_operand_fetch

Streams operand vectors from the local scratchpad SRAM into the vector engine. Given a base address, a stride and an element count per operand, it issues single-port SRAM reads: A then B for binary ops, A only for unary ops. It pairs the returned bytes and presents them as one (A, B) beat per element on a valid/ready stream. The stream's A/B lanes drive the engine's `data_a_in`/`data_b_in` directly.

## Interface
- `DATA_WIDTH`, 8, element width in bits
- `ADDR_WIDTH`, 16, SRAM byte address width
- `MAX_ELEMENTS`, 4096, upper bound on the element count; `CW = $clog2(MAX_ELEMENTS)`
- `FIFO_DEPTH`, 4, output pair FIFO depth (power of 2, ≥2)

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse; samples all cfg inputs; ignored while `busy`
- `busy`  out  1  high from the cycle after an accepted `start` until `done`, inclusive
- `done`  out  1  one-cycle pulse; the last pair has been accepted downstream
- `binary`  in  1  1: fetch A and B; 0: fetch A only, `b_data` = 0
- `bcast_b`  in  1  broadcast B (see Configuration)
- `base_a`, `base_b`  in  ADDR_WIDTH  operand start addresses
- `stride_a`, `stride_b`  in  ADDR_WIDTH  address increments per element
- `num_elements`  in  CW  element count; 0 is legal
- `sram_rd_en`  out  1  read strobe
- `sram_addr`  out  ADDR_WIDTH  read address
- `sram_rdata`  in  DATA_WIDTH  read data, valid exactly 1 cycle after `sram_rd_en`
- `a_data`, `b_data`  out  DATA_WIDTH  output pair
- `out_valid`  out  1  pair available (FIFO not empty)
- `out_ready`  in  1  consumer accepts the pair when `out_valid && out_ready`

## Operation
- FSM states are `IDLE`, `FETCH_A`, `FETCH_B`, `DRAIN` and `DONE`.
  - `IDLE` + `start` with `num_elements != 0` → `FETCH_A`.
  - `IDLE` + `start` with `num_elements == 0` → `DONE`.
  - `FETCH_A` issues an A read when credit is available; with no credit it holds and issues nothing.
  - After the A issue: → `FETCH_B` if `binary`, else stay in `FETCH_A`.
  - `FETCH_B` issues the B read (no credit check, credit was taken at the A issue), then → `FETCH_A`.
  - After the last element is issued → `DRAIN`.
  - `DRAIN` → `DONE` once the FIFO is empty, nothing is in flight, and the last pair was accepted.
  - `DONE` → `IDLE` after one cycle.
- Credit: an element may be issued only when `fifo_count + elements_in_flight < FIFO_DEPTH`. The FIFO never overflows.
- Addresses: `addr_a` starts at `base_a` and advances by `stride_a` after each A issue; `addr_b` likewise. Both wrap modulo 2^ADDR_WIDTH with no error.
- Returned A data is held in a pair register. The B return (binary) or the A return (unary) pushes `{A, B}` into the FIFO.
- Push and pop in the same cycle leave `fifo_count` unchanged.
- The cfg inputs are latched at `start`; later changes have no effect until the next `start`.
- A reset mid-operation aborts immediately: all state is cleared and in-flight read data is discarded.

## Timing
- Reset values:
  - `busy`, `done`, `sram_rd_en`, `out_valid` = 0
  - `sram_addr`, `a_data`, `b_data` = 0
  - FSM = `IDLE`, FIFO empty
- `start` is sampled at edge 0. The first `sram_rd_en` is in cycle 1 with `sram_addr` = `base_a`.
- First `out_valid`:
  - unary: cycle 3
  - binary: cycle 4 (B read in cycle 2, B data in cycle 3)
- Steady-state throughput with `out_ready` = 1: unary 1 element/cycle, binary 1 element per 2 cycles.
- `a_data`/`b_data` are stable while `out_valid && !out_ready`.
- `done` goes high the cycle after the final handshake. `busy` drops the cycle after `done`.

## Configuration
- `VEC_FETCH_BCAST_EN` defined:
  - When `binary && bcast_b`, B is read once at `base_b` in the first `FETCH_B` and then held.
  - Later elements skip `FETCH_B`: 1 element/cycle, B constant.
  - `stride_b` is ignored.
- Not defined: `bcast_b` is ignored and every binary element performs its own B read.

## Structure
- The `vec_pkg` package holds:
  - the `fetch_state_t` enum (`IDLE`, `FETCH_A`, `FETCH_B`, `DRAIN`, `DONE`)
  - the default `FIFO_DEPTH`
- Sub-module `vec_pair_fifo`:
  - synchronous first-word-fall-through FIFO, width 2·DATA_WIDTH, depth FIFO_DEPTH
  - outputs `count`, `empty`, `full`

## Test plan
- Unary copy, `base_a`=0x0100, `stride_a`=1, n=4, `out_ready`=1, SRAM[0x100..0x103]={1,2,3,4}:
  - pairs (1,0),(2,0),(3,0),(4,0) on consecutive cycles 3–6
  - `done` in cycle 7
- Binary, `base_a`=0x10, `base_b`=0x20, strides 2, n=3:
  - read addresses 0x10,0x20,0x12,0x22,0x14,0x24
  - pairs match SRAM contents, issued at 1 per 2 cycles
- Backpressure, `out_ready`=0 for 20 cycles, n=8 unary:
  - exactly 4 reads issued, then `sram_rd_en` stays low and the output is stable
  - releasing `out_ready` delivers all 8 in order
- `num_elements`=0:
  - no `sram_rd_en`
  - `done` pulses in cycle 2, `out_valid` stays 0
- Address wrap, `base_a`=0xFFFE, `stride_a`=1, n=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset asserted in cycle 5 of a binary n=8 run:
  - all outputs 0 in the same cycle
  - after release, a fresh `start` runs correctly
  - with `VEC_FETCH_BCAST_EN`, a bcast run of n=4 shows exactly one B read
